// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - register-read/issue stage feeding an external ALU with one execute slot
// Operands come from the register file or are forwarded from the result currently in the execute slot.
module alu_issue_stage #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [2:0]    InOp,
    input  logic [AW-1:0] InRa,
    input  logic [AW-1:0] InRb,
    input  logic [AW-1:0] InRd,
    input  logic          InUseImm,
    input  logic [DW-1:0] InImm,
    output logic [DW-1:0] InputA,
    output logic [DW-1:0] InputB,
    output logic [2:0]    OP,
    input  logic [DW-1:0] AluOut,
    output logic          ResValid,
    input  logic          ResReady,
    output logic [DW-1:0] ResData,
    output logic [AW-1:0] ResRd
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] rf_q [NREG];

    logic          e_valid_q, e_valid_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;

    logic          accept;
    logic          wb_en;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;

    assign InReady  = !e_valid_q || ResReady;
    assign accept   = InValid && InReady;
    assign wb_en    = e_valid_q && ResReady && (rd_q != '0);
    assign ResValid = e_valid_q;
    assign InputA   = a_q;
    assign InputB   = b_q;
    assign OP       = op_q;
    assign ResRd    = rd_q;
    assign ResData  = AluOut;

    // R0 wins over forwarding so a pending write to R0 never leaks into a read of it.
    always_comb begin
        opa = '0;
        if (InRa != '0) begin
            if (e_valid_q && (rd_q == InRa)) begin
                opa = AluOut;
            end else begin
                opa = rf_q[InRa];
            end
        end
    end

    always_comb begin
        opb = '0;
        if (InUseImm) begin
            opb = InImm;
        end else if (InRb != '0) begin
            if (e_valid_q && (rd_q == InRb)) begin
                opb = AluOut;
            end else begin
                opb = rf_q[InRb];
            end
        end
    end

    always_comb begin
        e_valid_d = e_valid_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        if (accept) begin
            e_valid_d = 1'b1;
            a_d       = opa;
            b_d       = opb;
            op_d      = InOp;
            rd_d      = InRd;
        end else if (e_valid_q && ResReady) begin
            e_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            e_valid_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
        end
    end

    // Entry 0 is cleared by reset and never written afterwards.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[rd_q] <= AluOut;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - table-driven scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

    logic       Clk;
    logic       Reset_n;
    logic       InValid;
    logic       InReady;
    logic [2:0] InOp;
    logic [2:0] InRa;
    logic [2:0] InRb;
    logic [2:0] InRd;
    logic       InUseImm;
    logic [7:0] InImm;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [2:0] OP;
    logic [7:0] AluOut;
    logic       ResValid;
    logic       ResReady;
    logic [7:0] ResData;
    logic [2:0] ResRd;

    alu_issue_stage #(.DW(8), .AW(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .InValid(InValid), .InReady(InReady),
        .InOp(InOp), .InRa(InRa), .InRb(InRb), .InRd(InRd),
        .InUseImm(InUseImm), .InImm(InImm),
        .InputA(InputA), .InputB(InputB), .OP(OP),
        .AluOut(AluOut),
        .ResValid(ResValid), .ResReady(ResReady),
        .ResData(ResData), .ResRd(ResRd)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // External ALU; opcodes 110/111 are arbitrary pass-throughs the stage must not care about.
    always_comb begin
        case (OP)
            3'b000:  AluOut = InputA + InputB;
            3'b001:  AluOut = InputA - InputB;
            3'b010:  AluOut = InputA & InputB;
            3'b011:  AluOut = InputA | InputB;
            3'b100:  AluOut = InputA ^ InputB;
            3'b101:  AluOut = InputA & ~InputB;
            3'b110:  AluOut = InputA;
            default: AluOut = InputB;
        endcase
    end

    typedef struct {
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rd;
        logic       ui;
        logic [7:0] imm;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] er;
    } vec_t;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;
    int   pops_before;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n && ResValid && ResReady) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", {24'd0, ResData}, {24'd0, e.res});
                chk("res_rd",   {29'd0, ResRd},   {29'd0, e.rd});
                chk("input_a",  {24'd0, InputA},  {24'd0, e.a});
                chk("input_b",  {24'd0, InputB},  {24'd0, e.b});
                chk("op",       {29'd0, OP},      {29'd0, e.op});
            end
            n_pops++;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input vec_t v);
        int   waited;
        exp_t e;
        InValid  = 1'b1;
        InOp     = v.op;
        InRa     = v.ra;
        InRb     = v.rb;
        InRd     = v.rd;
        InUseImm = v.ui;
        InImm    = v.imm;
        waited   = 0;
        @(negedge Clk);
        while (!InReady && waited < 20) begin
            waited++;
            @(negedge Clk);
        end
        if (!InReady) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.rd = v.rd; e.a = v.ea; e.b = v.eb; e.op = v.op; e.res = v.er;
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [2:0] rd, input logic ui, input logic [7:0] imm,
                                input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] er);
        vec_t v;
        v.op = op; v.ra = ra; v.rb = rb; v.rd = rd; v.ui = ui; v.imm = imm;
        v.ea = ea; v.eb = eb; v.er = er;
        return v;
    endfunction

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            w++;
            @(negedge Clk);
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        Reset_n  = 1'b0;
        InValid  = 1'b0;
        InOp     = 3'b000;
        InRa     = 3'd0;
        InRb     = 3'd0;
        InRd     = 3'd0;
        InUseImm = 1'b0;
        InImm    = 8'h00;
        ResReady = 1'b1;

        vecs[0]  = mk(3'b000, 3'd0, 3'd0, 3'd1, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05);
        vecs[1]  = mk(3'b000, 3'd1, 3'd0, 3'd2, 1'b1, 8'h03, 8'h05, 8'h03, 8'h08);
        vecs[2]  = mk(3'b001, 3'd2, 3'd1, 3'd3, 1'b0, 8'h00, 8'h08, 8'h05, 8'h03);
        vecs[3]  = mk(3'b010, 3'd2, 3'd0, 3'd4, 1'b1, 8'h0C, 8'h08, 8'h0C, 8'h08);
        vecs[4]  = mk(3'b011, 3'd3, 3'd4, 3'd5, 1'b0, 8'h00, 8'h03, 8'h08, 8'h0B);
        vecs[5]  = mk(3'b100, 3'd5, 3'd0, 3'd6, 1'b1, 8'hFF, 8'h0B, 8'hFF, 8'hF4);
        vecs[6]  = mk(3'b110, 3'd6, 3'd1, 3'd7, 1'b0, 8'h00, 8'hF4, 8'h05, 8'hF4);
        vecs[7]  = mk(3'b111, 3'd7, 3'd0, 3'd1, 1'b1, 8'h33, 8'hF4, 8'h33, 8'h33);
        vecs[8]  = mk(3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 8'h07, 8'h00, 8'h07, 8'h07);
        vecs[9]  = mk(3'b000, 3'd0, 3'd2, 3'd2, 1'b0, 8'h00, 8'h00, 8'h08, 8'h08);
        vecs[10] = mk(3'b000, 3'd0, 3'd0, 3'd1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF);
        vecs[11] = mk(3'b000, 3'd1, 3'd0, 3'd1, 1'b1, 8'h01, 8'hFF, 8'h01, 8'h00);
        vecs[12] = mk(3'b000, 3'd1, 3'd0, 3'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        #12;
        chk("rst_in_ready",  {31'd0, InReady},  32'd1);
        chk("rst_res_valid", {31'd0, ResValid}, 32'd0);
        chk("rst_input_a",   {24'd0, InputA},   32'd0);
        chk("rst_input_b",   {24'd0, InputB},   32'd0);
        chk("rst_op",        {29'd0, OP},       32'd0);
        chk("rst_res_rd",    {29'd0, ResRd},    32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int r = 1; r < 8; r++) begin
            issue(mk(3'b000, 3'(r), 3'(r), 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        end
        drain();

        @(posedge Clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i]);
        end
        drain();

        // Stall: hold the R4 result while a dependent R5 instruction waits upstream.
        @(posedge Clk);
        #1;
        ResReady = 1'b0;
        issue(mk(3'b000, 3'd0, 3'd0, 3'd4, 1'b1, 8'h2A, 8'h00, 8'h2A, 8'h2A));
        InValid  = 1'b1;
        InOp     = 3'b000;
        InRa     = 3'd4;
        InRb     = 3'd0;
        InRd     = 3'd5;
        InUseImm = 1'b1;
        InImm    = 8'h01;
        pops_before = n_pops;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("stall_in_ready",  {31'd0, InReady},  32'd0);
            chk("stall_res_valid", {31'd0, ResValid}, 32'd1);
            chk("stall_input_a",   {24'd0, InputA},   32'h00);
            chk("stall_input_b",   {24'd0, InputB},   32'h2A);
            chk("stall_res_rd",    {29'd0, ResRd},    32'd4);
            chk("stall_op",        {29'd0, OP},       32'd0);
        end
        @(posedge Clk);
        #1;
        ResReady = 1'b1;
        @(negedge Clk);
        chk("unstall_in_ready", {31'd0, InReady}, 32'd1);
        begin
            exp_t e;
            e.rd = 3'd5; e.a = 8'h2A; e.b = 8'h01; e.op = 3'b000; e.res = 8'h2B;
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("stall_pop_count", n_pops - pops_before, 32'd2);
        chk("stall_sb_empty", sb.size(), 32'd0);
        @(posedge Clk);
        #1;
        issue(mk(3'b000, 3'd4, 3'd5, 3'd6, 1'b0, 8'h00, 8'h2A, 8'h2B, 8'h55));
        drain();

        // Reset while a result is pending: it must vanish without writeback.
        @(posedge Clk);
        #1;
        ResReady = 1'b0;
        issue(mk(3'b000, 3'd0, 3'd0, 3'd3, 1'b1, 8'h09, 8'h00, 8'h09, 8'h09));
        @(negedge Clk);
        chk("pre_rst_res_valid", {31'd0, ResValid}, 32'd1);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'd0, ResValid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, InReady},  32'd1);
        chk("mid_rst_input_a",   {24'd0, InputA},   32'd0);
        chk("mid_rst_input_b",   {24'd0, InputB},   32'd0);
        chk("mid_rst_op",        {29'd0, OP},       32'd0);
        sb.delete();
        @(negedge Clk);
        Reset_n  = 1'b1;
        ResReady = 1'b1;
        @(posedge Clk);
        #1;
        issue(mk(3'b000, 3'd3, 3'd0, 3'd4, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00));
        issue(mk(3'b000, 3'd2, 3'd6, 3'd5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The module SHALL have parameter DW, default 8, meaning the datapath width in bits.
REQ-002 The module SHALL have parameter AW, default 3, meaning the register-address width (2**AW registers).
REQ-003 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InValid  input  1  upstream instruction valid.
- InReady  output  1  stage can accept an instruction this cycle.
- InOp  input  3  ALU opcode, forwarded unmodified.
- InRa  input  AW  source register for operand A.
- InRb  input  AW  source register for operand B.
- InRd  input  AW  destination register.
- InUseImm  input  1  1 = operand B taken from InImm instead of InRb.
- InImm  input  DW  immediate operand.
- InputA  output  DW  registered operand A to ALU.
- InputB  output  DW  registered operand B to ALU.
- OP  output  3  registered opcode to ALU.
- AluOut  input  DW  combinational ALU result for InputA/InputB/OP.
- ResValid  output  1  result in execute slot valid.
- ResReady  input  1  downstream accepts result.
- ResData  output  DW  equals AluOut.
- ResRd  output  AW  destination of current result.

Function
REQ-004 The stage SHALL contain a register file of 2**AW entries of DW bits; register 0 SHALL read as 0, and writes to it SHALL be discarded.
REQ-005 The stage SHALL contain one execute slot (e_valid, InputA, InputB, OP, ResRd); ResValid SHALL equal e_valid.
REQ-006 InReady SHALL be !e_valid || ResReady (combinational).
REQ-007 Accept SHALL occur when InValid && InReady; on accept, the slot SHALL load e_valid=1, OP=InOp, ResRd=InRd, and both operands per REQ-008/009.
REQ-008 Operand A SHALL be 0 if InRa==0; otherwise AluOut if e_valid && ResRd==InRa (forwarding); otherwise regfile[InRa].
REQ-009 Operand B SHALL be InImm if InUseImm=1; otherwise it SHALL be resolved from InRb using the REQ-008 rules.
REQ-010 Writeback SHALL occur when e_valid && ResReady: regfile[ResRd] <= AluOut at that edge, unless ResRd==0.
REQ-011 When e_valid && !ResReady (stall), the slot, the outputs and the register file SHALL hold unchanged, and no accept SHALL occur.
REQ-012 When e_valid && ResReady && !(InValid), e_valid SHALL clear at the edge; InputA/InputB/OP/ResRd SHALL hold their last values.
REQ-013 Simultaneous writeback and accept SHALL be legal; forwarding (REQ-008) SHALL give the new instruction the value being written that cycle.
REQ-014 Throughput SHALL be one instruction per cycle with no bubbles for back-to-back dependent instructions; latency from accept to ResValid SHALL be 1 cycle.
REQ-015 The stage SHALL NOT interpret OP; undefined opcodes (110, 111) SHALL pass through, and whatever AluOut returns SHALL be written back.
REQ-016 Arithmetic SHALL be modulo 2**DW; the stage SHALL perform no width extension, and no carry/overflow SHALL be kept.

Reset
REQ-017 While Reset_n=0, the stage SHALL asynchronously force e_valid=0, InputA=0, InputB=0, OP=000, ResRd=0 and all register-file entries to 0; InReady SHALL be 1 and ResValid SHALL be 0.
REQ-018 Reset asserted with ResValid=1 SHALL discard that result without writeback; the first accept SHALL be possible on the first rising edge after Reset_n rises.

Verification
REQ-019 The bench SHALL cover: reset -> InReady=1, ResValid=0, InputA=InputB=00, OP=000; afterwards, reads of R1..R7 give operand 00.
REQ-020 The bench SHALL cover: accept ADD R1=R0+imm 05, then next cycle ADD R2=R1+imm 03 -> second slot InputA=05 (forwarded), ResData=08; later, read of R2 gives 08.
REQ-021 The bench SHALL cover: ResValid=1 with ResReady=0 for 3 cycles -> InputA/InputB/OP/ResRd stable, InReady=0, register file unchanged; ResReady=1 -> exactly one writeback.
REQ-022 The bench SHALL cover: ADD R0=R0+imm 07, then read R0 -> InputA=00.
REQ-023 The bench SHALL cover: R1=imm FF, then ADD R1=R1+imm 01 -> ResData=00, and R1 reads 00.
REQ-024 The bench SHALL cover: Reset_n pulsed low mid-cycle while ResValid=1 for R3=imm 09 -> ResValid=0 immediately, and R3 reads 00 after reset.
